// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath_seq execution core: opcodes,
// sequencer states and instruction field positions.
package datapath_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OP_W-1:0] OP_AND  = 5'd2;
  localparam logic [OP_W-1:0] OP_OR   = 5'd3;
  localparam logic [OP_W-1:0] OP_MUL  = 5'd4;
  localparam logic [OP_W-1:0] OP_MFHI = 5'd5;
  localparam logic [OP_W-1:0] OP_MFLO = 5'd6;
  localparam logic [OP_W-1:0] OP_HALT = 5'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_T5   = 3'd6,
    ST_HALT = 3'd7
  } state_e;

  // Register fields sit directly below the opcode: idx 0 = ra, 1 = rb, 2 = rc.
  function automatic int field_lsb(input int data_w, input int reg_aw, input int idx);
    return data_w - OP_W - (idx + 1) * reg_aw;
  endfunction

endpackage

// File: rtl/reg_file_param.sv
// General-purpose register file: one write port, two operand read ports
// and a debug read port. All reads are combinational, so a read of the
// register being written shows the value from before the edge.
module reg_file_param #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32
) (
  input  logic                        clock,
  input  logic                        clear,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] waddr,
  input  logic [DATA_W-1:0]           wdata,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_a,
  output logic [DATA_W-1:0]           rdata_a,
  input  logic [$clog2(NUM_REGS)-1:0] raddr_b,
  output logic [DATA_W-1:0]           rdata_b,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]           dbg_rdata
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] wr_hit_d;

  // Decode the write address into a one-hot per-register enable.
  always_comb begin
    wr_hit_d = '0;
    if (we) begin
      wr_hit_d[waddr] = 1'b1;
    end
  end

  // Storage: only the addressed entry is updated on a write.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit_d[i]) begin
          regs_q[i] <= wdata;
        end
      end
    end
  end

  assign rdata_a   = regs_q[raddr_a];
  assign rdata_b   = regs_q[raddr_b];
  assign dbg_rdata = regs_q[dbg_addr];

endmodule

// File: rtl/datapath_seq.sv
// Single-bus datapath with a built-in T0..T5 microstep sequencer that
// fetches and executes register-register ALU instructions.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for run
// T0    | MAR <= PC, Z <= PC+1
// T1    | fetch request; wait for mem_ack, then MDR <= data, PC <= Zlow
// T2    | IR <= MDR
// T3    | Y <= R[rb]
// T4    | Z <= Y op R[rc]
// T5    | writeback / HI,LO update / halt / illegal flag
// HALT  | terminal; only clear leaves it
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                        clock,
  input  logic                        clear,
  input  logic                        run,
  output logic [DATA_W-1:0]           mem_addr,
  output logic                        mem_req,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_sel,
  output logic [DATA_W-1:0]           dbg_rdata,
  output logic [DATA_W-1:0]           pc,
  output logic                        busy,
  output logic                        halted,
  output logic                        illegal
);

  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int OP_LSB = DATA_W - OP_W;
  localparam int RA_LSB = field_lsb(DATA_W, REG_AW, 0);
  localparam int RB_LSB = field_lsb(DATA_W, REG_AW, 1);
  localparam int RC_LSB = field_lsb(DATA_W, REG_AW, 2);
  localparam logic [DATA_W-1:0] ZERO_W = '0;

  if (DATA_W < OP_W + 3 * REG_AW) begin : g_bad_width
    $error("datapath_seq: DATA_W too narrow for opcode and three register fields");
  end
  if (NUM_REGS < 2 || (1 << REG_AW) != NUM_REGS) begin : g_bad_regs
    $error("datapath_seq: NUM_REGS must be a power of two and at least 2");
  end

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic [2*DATA_W-1:0] z_q, z_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                halted_q, halted_d;
  logic                illegal_q, illegal_d;

  logic [OP_W-1:0]     op;
  logic [REG_AW-1:0]   ra, rb, rc;
  logic [DATA_W-1:0]   pc_inc;
  logic [2*DATA_W-1:0] product;
  logic [DATA_W-1:0]   rf_rdata_a, rf_rdata_b;
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;

  assign op = ir_q[OP_LSB +: OP_W];
  assign ra = ir_q[RA_LSB +: REG_AW];
  assign rb = ir_q[RB_LSB +: REG_AW];
  assign rc = ir_q[RC_LSB +: REG_AW];

  // Bits below rc carry no meaning for this instruction set.
  if (RC_LSB > 0) begin : g_ir_pad
    logic ir_pad_unused;
    assign ir_pad_unused = ^ir_q[RC_LSB-1:0];
  end

  assign pc_inc  = pc_q + {{(DATA_W-1){1'b0}}, 1'b1};
  assign product = {ZERO_W, y_q} * {ZERO_W, rf_rdata_b};

  reg_file_param #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) u_rf (
    .clock     (clock),
    .clear     (clear),
    .we        (rf_we),
    .waddr     (ra),
    .wdata     (rf_wdata),
    .raddr_a   (rb),
    .rdata_a   (rf_rdata_a),
    .raddr_b   (rc),
    .rdata_b   (rf_rdata_b),
    .dbg_addr  (dbg_sel),
    .dbg_rdata (dbg_rdata)
  );

  // Sequencer next state plus all datapath register transfers per microstep.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    y_d       = y_q;
    z_d       = z_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    rf_wdata  = z_q[DATA_W-1:0];

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_T0;
        end
      end
      ST_T0: begin
        mar_d   = pc_q;
        z_d     = {ZERO_W, pc_inc};
        state_d = ST_T1;
      end
      ST_T1: begin
        if (mem_ack) begin
          mdr_d   = mem_rdata;
          pc_d    = z_q[DATA_W-1:0];
          state_d = ST_T2;
        end
      end
      ST_T2: begin
        ir_d    = mdr_q;
        state_d = ST_T3;
      end
      ST_T3: begin
        y_d     = rf_rdata_a;
        state_d = ST_T4;
      end
      ST_T4: begin
        case (op)
          OP_ADD:  z_d = {ZERO_W, y_q + rf_rdata_b};
          OP_SUB:  z_d = {ZERO_W, y_q - rf_rdata_b};
          OP_AND:  z_d = {ZERO_W, y_q & rf_rdata_b};
          OP_OR:   z_d = {ZERO_W, y_q | rf_rdata_b};
          OP_MUL:  z_d = product;
          default: z_d = z_q;
        endcase
        state_d = ST_T5;
      end
      ST_T5: begin
        // Undefined opcodes flag illegal but never write back.
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            rf_we    = 1'b1;
            rf_wdata = z_q[DATA_W-1:0];
          end
          OP_MUL: begin
            hi_d = z_q[2*DATA_W-1:DATA_W];
            lo_d = z_q[DATA_W-1:0];
          end
          OP_MFHI: begin
            rf_we    = 1'b1;
            rf_wdata = hi_q;
          end
          OP_MFLO: begin
            rf_we    = 1'b1;
            rf_wdata = lo_q;
          end
          OP_HALT: begin
            halted_d = 1'b1;
          end
          default: begin
            illegal_d = 1'b1;
          end
        endcase
        if (op == OP_HALT) begin
          state_d = ST_HALT;
        end else if (run) begin
          state_d = ST_T0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath and sequencer registers; clear aborts any instruction in flight.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      y_q       <= '0;
      z_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      y_q       <= y_d;
      z_q       <= z_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign mem_addr = mar_q;
  assign mem_req  = (state_q == ST_T1);
  assign pc       = pc_q;
  assign busy     = (state_q inside {ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5});
  assign halted   = halted_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq: a 32-bit/16-register instance for the
// main scenarios and a 16-bit/8-register instance for the narrow decode.
`timescale 1ns/1ps
module tb_datapath_seq;
  import datapath_pkg::*;

  localparam int W   = 32;
  localparam int NR  = 16;
  localparam int AW  = 4;
  localparam int WS  = 16;
  localparam int NRS = 8;
  localparam int AWS = 3;

  logic          clock;
  logic          clear, run, mem_req, mem_ack, busy, halted, illegal;
  logic [W-1:0]  mem_addr, mem_rdata, dbg_rdata, pc;
  logic [AW-1:0] dbg_sel;

  logic           clear_s, run_s, mem_req_s, mem_ack_s, busy_s, halted_s, illegal_s;
  logic [WS-1:0]  mem_addr_s, mem_rdata_s, dbg_rdata_s, pc_s;
  logic [AWS-1:0] dbg_sel_s;

  logic [W-1:0]  imem   [64];
  logic [WS-1:0] imem_s [64];
  int ack_delay;
  int wait_cnt;
  int checks;
  int errors;

  datapath_seq #(.DATA_W(W), .NUM_REGS(NR)) dut (
    .clock(clock), .clear(clear), .run(run),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_sel(dbg_sel), .dbg_rdata(dbg_rdata), .pc(pc),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  datapath_seq #(.DATA_W(WS), .NUM_REGS(NRS)) dut_s (
    .clock(clock), .clear(clear_s), .run(run_s),
    .mem_addr(mem_addr_s), .mem_req(mem_req_s), .mem_ack(mem_ack_s), .mem_rdata(mem_rdata_s),
    .dbg_sel(dbg_sel_s), .dbg_rdata(dbg_rdata_s), .pc(pc_s),
    .busy(busy_s), .halted(halted_s), .illegal(illegal_s)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Instruction memory for the wide instance, with programmable ack delay.
  initial begin
    mem_ack = 1'b0; mem_rdata = '0; wait_cnt = 0;
    forever begin
      @(negedge clock);
      if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1; mem_rdata = imem[mem_addr[5:0]]; wait_cnt = 0;
        end else begin
          mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF; wait_cnt++;
        end
      end else begin
        mem_ack = 1'b0; mem_rdata = '0; wait_cnt = 0;
      end
    end
  end

  // Zero-wait instruction memory for the narrow instance.
  initial begin
    mem_ack_s = 1'b0; mem_rdata_s = '0;
    forever begin
      @(negedge clock);
      mem_ack_s   = mem_req_s;
      mem_rdata_s = mem_req_s ? imem_s[mem_addr_s[5:0]] : '0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] enc(input logic [4:0] op, input int ra, input int rb, input int rc);
    logic [W-1:0] w;
    w = '0;
    w[31:27] = op; w[26:23] = 4'(ra); w[22:19] = 4'(rb); w[18:15] = 4'(rc);
    return w;
  endfunction

  function automatic logic [WS-1:0] enc_s(input logic [4:0] op, input int ra, input int rb, input int rc);
    logic [WS-1:0] w;
    w = '0;
    w[15:11] = op; w[10:8] = 3'(ra); w[7:5] = 3'(rb); w[4:2] = 3'(rc);
    return w;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic poke(input int idx, input logic [W-1:0] val);
    dut.u_rf.regs_q[idx] = val;
  endtask

  task automatic do_reset();
    run = 1'b0; ack_delay = 0; clear = 1'b0;
    step(2);
    clear = 1'b1;
    step(1);
    for (int i = 0; i < 64; i++) imem[i] = enc(OP_HALT, 0, 0, 0);
  endtask

  task automatic wait_halted(input int bound, input string name);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < bound) begin
      step(1);
      n++;
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL %s_halt_timeout: halted=%0b after %0d cycles, expected 1", name, halted, n);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1; run = 1'b0; dbg_sel = '0;
    step(3);
    clear = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0b expected 0", mem_req); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (pc !== '0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (halted !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL reset_flags: got halted=%0b illegal=%0b expected 0 0", halted, illegal); end
    checks++; if (dbg_rdata !== '0) begin errors++; $display("FAIL reset_dbg: got %h expected 0", dbg_rdata); end
    step(2);
    clear = 1'b1;
    step(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_no_run: busy got %0b expected 0", busy); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    imem[0] = enc(OP_ADD, 1, 0, 0);
    imem[1] = enc(OP_ADD, 1, 0, 0);
    poke(1, 32'h55);
    run = 1'b1;
    step(1);
    checks++; if (busy !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL ff_t0: got busy=%0b req=%0b expected 1 0", busy, mem_req); end
    step(1);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd0) begin errors++; $display("FAIL ff_t1: got req=%0b addr=%h expected 1 0", mem_req, mem_addr); end
    step(1);
    checks++; if (pc !== 32'd1 || mem_req !== 1'b0) begin errors++; $display("FAIL ff_pc: got pc=%h req=%0b expected 1 0", pc, mem_req); end
    step(4);
    checks++; if (busy !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL ff_next_t0: got busy=%0b req=%0b expected 1 0", busy, mem_req); end
    step(1);
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'd1) begin errors++; $display("FAIL ff_second_fetch: got req=%0b addr=%h expected 1 1", mem_req, mem_addr); end
    run = 1'b0;
    step(5);
    dbg_sel = 4'd1;
    #1;
    checks++; if (busy !== 1'b0 || pc !== 32'd2) begin errors++; $display("FAIL ff_idle: got busy=%0b pc=%h expected 0 2", busy, pc); end
    checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL ff_r1: got %h expected 0", dbg_rdata); end
  endtask

  task automatic test_wait_states();
    int n;
    do_reset();
    ack_delay = 3;
    imem[0] = enc(OP_ADD, 1, 0, 0);
    imem[1] = enc(OP_ADD, 2, 0, 0);
    run = 1'b1;
    step(2);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'd0 || dut.mdr_q !== 32'd0) begin
        errors++;
        $display("FAIL ws_t1_hold%0d: got req=%0b addr=%h mdr=%h expected 1 0 0", k, mem_req, mem_addr, dut.mdr_q);
      end
      step(1);
    end
    checks++; if (mem_req !== 1'b0 || dut.mdr_q !== imem[0] || pc !== 32'd1) begin errors++; $display("FAIL ws_capture: got req=%0b mdr=%h pc=%h expected 0 %h 1", mem_req, dut.mdr_q, pc, imem[0]); end
    n = 0;
    while (mem_req !== 1'b1 && n < 30) begin
      step(1);
      n++;
    end
    checks++; if (4 + n != 9) begin errors++; $display("FAIL ws_instr_time: got %0d cycles expected 9", 4 + n); end
    run = 1'b0;
    ack_delay = 0;
  endtask

  task automatic test_alu();
    int idx_tab [9] = '{4, 5, 6, 7, 8, 9, 3, 2, 0};
    logic [W-1:0] val_tab [9] = '{32'h1, 32'h3, 32'h1, 32'hFFFF_FFFE, 32'h2, 32'hFFFF_FFFF, 32'h4, 32'hFFFF_FFFF, 32'h0};
    do_reset();
    poke(2, 32'hFFFF_FFFF);
    poke(3, 32'h2);
    imem[0] = enc(OP_ADD, 4, 2, 3);
    imem[1] = enc(OP_SUB, 5, 3, 2);
    imem[2] = enc(OP_MUL, 0, 2, 3);
    imem[3] = enc(OP_MFHI, 6, 0, 0);
    imem[4] = enc(OP_MFLO, 7, 0, 0);
    imem[5] = enc(OP_AND, 8, 2, 3);
    imem[6] = enc(OP_OR, 9, 2, 3);
    imem[7] = enc(OP_ADD, 3, 3, 3);
    imem[8] = enc(OP_HALT, 0, 0, 0);
    run = 1'b1;
    wait_halted(120, "alu");
    for (int i = 0; i < 9; i++) begin
      dbg_sel = AW'(idx_tab[i]);
      #1;
      checks++;
      if (dbg_rdata !== val_tab[i]) begin errors++; $display("FAIL alu_r%0d: got %h expected %h", idx_tab[i], dbg_rdata, val_tab[i]); end
    end
    checks++; if (pc !== 32'd9 || busy !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL alu_end: got pc=%h busy=%0b illegal=%0b expected 9 0 0", pc, busy, illegal); end
  endtask

  task automatic test_illegal();
    do_reset();
    poke(2, 32'd5);
    poke(3, 32'd7);
    poke(4, 32'h99);
    imem[0] = enc(5'h1F, 2, 3, 3);
    imem[1] = enc(OP_ADD, 4, 2, 3);
    imem[2] = enc(OP_HALT, 0, 0, 0);
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_before: got %0b expected 0", illegal); end
    run = 1'b1;
    step(7);
    dbg_sel = 4'd2;
    #1;
    checks++; if (illegal !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ill_flag: got illegal=%0b busy=%0b expected 1 1", illegal, busy); end
    checks++; if (dbg_rdata !== 32'd5) begin errors++; $display("FAIL ill_no_wb: got R2=%h expected 5", dbg_rdata); end
    wait_halted(40, "ill");
    dbg_sel = 4'd4;
    #1;
    checks++; if (dbg_rdata !== 32'd12) begin errors++; $display("FAIL ill_next_instr: got R4=%h expected c", dbg_rdata); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_sticky: got %0b expected 1", illegal); end
  endtask

  task automatic test_halt();
    bit saw_activity;
    do_reset();
    poke(9, 32'hABCD);
    for (int i = 0; i < 5; i++) imem[i] = enc(OP_ADD, 1, 0, 0);
    imem[5] = enc(OP_HALT, 0, 0, 0);
    run = 1'b1;
    wait_halted(60, "halt");
    checks++; if (pc !== 32'd6 || busy !== 1'b0) begin errors++; $display("FAIL halt_state: got pc=%h busy=%0b expected 6 0", pc, busy); end
    saw_activity = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (mem_req !== 1'b0 || busy !== 1'b0) saw_activity = 1'b1;
    end
    checks++; if (saw_activity !== 1'b0 || halted !== 1'b1) begin errors++; $display("FAIL halt_terminal: got activity=%0b halted=%0b expected 0 1", saw_activity, halted); end
    dbg_sel = 4'd9;
    clear = 1'b0;
    #1;
    checks++; if (mem_addr !== '0 || pc !== '0 || mem_req !== 1'b0) begin errors++; $display("FAIL halt_clear_bus: got addr=%h pc=%h req=%0b expected 0 0 0", mem_addr, pc, mem_req); end
    checks++; if (halted !== 1'b0 || illegal !== 1'b0 || busy !== 1'b0 || dbg_rdata !== '0) begin errors++; $display("FAIL halt_clear_flags: got halted=%0b illegal=%0b busy=%0b dbg=%h expected 0 0 0 0", halted, illegal, busy, dbg_rdata); end
    run = 1'b0;
    step(1);
    clear = 1'b1;
  endtask

  task automatic test_run_drop();
    do_reset();
    poke(2, 32'd10);
    poke(3, 32'd3);
    poke(4, 32'h99);
    poke(5, 32'h42);
    imem[0] = enc(OP_SUB, 4, 2, 3);
    imem[1] = enc(OP_ADD, 5, 2, 3);
    run = 1'b1;
    step(4);
    run = 1'b0;
    step(2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_t5_busy: got %0b expected 1", busy); end
    step(1);
    dbg_sel = 4'd4;
    #1;
    checks++; if (busy !== 1'b0 || dbg_rdata !== 32'd7) begin errors++; $display("FAIL drop_complete: got busy=%0b R4=%h expected 0 7", busy, dbg_rdata); end
    step(3);
    dbg_sel = 4'd5;
    #1;
    checks++; if (mem_req !== 1'b0 || pc !== 32'd1 || dbg_rdata !== 32'h42) begin errors++; $display("FAIL drop_idle: got req=%0b pc=%h R5=%h expected 0 1 42", mem_req, pc, dbg_rdata); end

    do_reset();
    poke(2, 32'd10);
    poke(3, 32'd3);
    imem[0] = enc(OP_SUB, 4, 2, 3);
    run = 1'b1;
    step(5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_in_t4: got busy=%0b expected 1", busy); end
    clear = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || pc !== '0) begin errors++; $display("FAIL abort_immediate: got busy=%0b pc=%h expected 0 0", busy, pc); end
    run = 1'b0;
    step(1);
    clear = 1'b1;
    step(8);
    dbg_sel = 4'd4;
    #1;
    checks++; if (dbg_rdata !== 32'd0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_wb: got R4=%h busy=%0b expected 0 0", dbg_rdata, busy); end
  endtask

  task automatic test_narrow();
    int n;
    int idx_tab [6] = '{3, 4, 5, 6, 7, 1};
    logic [WS-1:0] val_tab [6] = '{16'h1, 16'h3, 16'h1, 16'hFFFE, 16'hFFFE, 16'hFFFF};
    clear_s = 1'b0; run_s = 1'b0; dbg_sel_s = '0;
    step(2);
    clear_s = 1'b1;
    step(1);
    for (int i = 0; i < 64; i++) imem_s[i] = enc_s(OP_HALT, 0, 0, 0);
    imem_s[0] = enc_s(OP_ADD, 3, 1, 2);
    imem_s[1] = enc_s(OP_SUB, 4, 2, 1);
    imem_s[2] = enc_s(OP_MUL, 0, 1, 2);
    imem_s[3] = enc_s(OP_MFHI, 5, 0, 0);
    imem_s[4] = enc_s(OP_MFLO, 6, 0, 0);
    imem_s[5] = enc_s(OP_ADD, 7, 1, 1);
    imem_s[6] = enc_s(5'h1F, 1, 2, 2);
    imem_s[7] = enc_s(OP_HALT, 0, 0, 0);
    dut_s.u_rf.regs_q[1] = 16'hFFFF;
    dut_s.u_rf.regs_q[2] = 16'h0002;
    run_s = 1'b1;
    n = 0;
    while (halted_s !== 1'b1 && n < 100) begin
      step(1);
      n++;
    end
    checks++; if (halted_s !== 1'b1) begin errors++; $display("FAIL narrow_halt_timeout: halted=%0b after %0d cycles, expected 1", halted_s, n); end
    for (int i = 0; i < 6; i++) begin
      dbg_sel_s = AWS'(idx_tab[i]);
      #1;
      checks++;
      if (dbg_rdata_s !== val_tab[i]) begin errors++; $display("FAIL narrow_r%0d: got %h expected %h", idx_tab[i], dbg_rdata_s, val_tab[i]); end
    end
    checks++; if (pc_s !== 16'd8 || illegal_s !== 1'b1) begin errors++; $display("FAIL narrow_end: got pc=%h illegal=%0b expected 8 1", pc_s, illegal_s); end
    run_s = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; ack_delay = 0;
    clear = 1'b1; run = 1'b0; dbg_sel = '0;
    clear_s = 1'b0; run_s = 1'b0; dbg_sel_s = '0;
    for (int i = 0; i < 64; i++) begin
      imem[i] = '0;
      imem_s[i] = '0;
    end
    test_reset();
    test_first_fetch();
    test_wait_states();
    test_alu();
    test_illegal();
    test_halt();
    test_run_drop();
    test_narrow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
Parametrised successor to the single-bus Mini SRC datapath. It combines a NUM_REGS x DATA_W register file, PC, IR, MAR, MDR, Y, a 2*DATA_W Z register and HI/LO with an internal T0-T5 microstep sequencer, so register-register instructions are fetched and executed without an external control unit. It sits between the instruction memory port and the future full control unit, and serves as the execution core for register ALU ops.

Parameters:
DATA_W, 32, datapath and instruction width
NUM_REGS, 16, general-purpose register count (power of 2, >= 2)
REG_AW, $clog2(NUM_REGS), register field width (localparam); DATA_W >= 5 + 3*REG_AW is required, enforced by elaboration-time check

Ports:
clock  in  1  single system clock, rising edge
clear  in  1  asynchronous active-low reset
run  in  1  level; start/continue execution
mem_addr  out  DATA_W  instruction fetch address (MAR)
mem_req  out  1  fetch request
mem_ack  in  1  fetch complete; mem_rdata valid this cycle
mem_rdata  in  DATA_W  fetched instruction word
dbg_sel  in  REG_AW  register-file debug read select
dbg_rdata  out  DATA_W  R[dbg_sel], combinational
pc  out  DATA_W  current PC
busy  out  1  high in T0..T5
halted  out  1  sticky; HALT executed
illegal  out  1  sticky; undefined opcode seen

Behaviour:
- Clock is clock; reset is clear, asynchronous, active-low. While clear=0, all registers (R*, PC, IR, MAR, MDR, Y, Z, HI, LO), state=IDLE, and all outputs are 0. Reset mid-instruction aborts immediately; no partial writeback survives.
- Instruction fields: op=IR[DATA_W-1 -: 5], ra=next REG_AW bits below op, rb next, rc next; remaining bits ignored.
- Opcodes: ADD=0 (Ra=Rb+Rc), SUB=1 (Ra=Rb-Rc), AND=2, OR=3, MUL=4 ({HI,LO}=Rb*Rc, unsigned, full 2*DATA_W), MFHI=5 (Ra=HI), MFLO=6 (Ra=LO), HALT=7. Any other op: illegal<=1, no writeback, execution continues.
- ADD/SUB wrap modulo 2^DATA_W; no flags.
- States: IDLE, T0, T1, T2, T3, T4, T5, HALT.
- IDLE: when run=1, go to T0 next edge; otherwise stay.
- T0: MAR<=PC; Z<=PC+1 (mod 2^DATA_W).
- T1: mem_req=1, mem_addr=MAR. Stay in T1 until mem_ack=1; on ack, MDR<=mem_rdata, PC<=Zlow, go to T2. Ack in the first T1 cycle is legal, so minimum instruction latency is 6 cycles. mem_req is 0 in all other states.
- T2: IR<=MDR.
- T3: Y<=R[rb].
- T4: Z<=Y op R[rc]. Logic ops zero-extend into Z. MUL places the full product in Z.
- T5: ADD/SUB/AND/OR write R[ra]<=Zlow. MUL writes HI<=Zhigh, LO<=Zlow. MFHI/MFLO write R[ra]<=HI or LO. HALT sets halted=1 and goes to HALT. Otherwise go to T0 if run=1, else IDLE.
- run dropping mid-instruction does not abort; the instruction completes and the sequencer then returns to IDLE.
- HALT state is terminal; it exits only via clear.
- ra==rb or ra==rc is legal: sources are sampled in T3/T4, before the T5 write.
- dbg_rdata shows the pre-edge value in the cycle R[ra] is written.
- busy=1 exactly in T0..T5.

Decomposition:
- Package datapath_pkg: opcode constants (OP_ADD..OP_HALT), state enum/encoding, field-position helper constants.
- One sub-module: reg_file_param (parameters NUM_REGS, DATA_W; async active-low clear; one write port; two read ports plus one debug read port).
- ALU stays inline in the T4 logic.

Test Plan:
- Reset then run=1 with zero-wait memory returning ADD R1,R0,R0 at addr 0 -> mem_req high in cycle 2, R1=0, PC=1, busy falls back to T0 after 6 cycles, and mem_addr=1 on the next fetch.
- Preload via fetched ops; memory with mem_ack delayed 3 cycles -> stays in T1 for 3 cycles with mem_addr stable, MDR captured only on the ack cycle, total instruction time 9 cycles.
- R2=0xFFFFFFFF, R3=2: ADD R4,R2,R3 -> R4=1; SUB R5,R3,R2 -> R5=3; MUL R2,R3 -> HI=1, LO=0xFFFFFFFE; MFHI R6 -> R6=1; MFLO R7 -> R7=0xFFFFFFFE.
- Opcode 0x1F fetched -> illegal=1, no register changes, next instruction executes normally, illegal stays 1.
- HALT at addr 5 -> halted=1, mem_req stays 0 thereafter even with run=1; clear low -> all outputs 0.
- run dropped during T3 -> T4/T5 complete with correct writeback, then IDLE; clear asserted during T4 -> immediate IDLE with destination register unchanged (0). Rerun the suite with DATA_W=16, NUM_REGS=8 to exercise the parametrised field decode and wrap.
